bhg_psg_mixer_n: RTL



---
 rtl/bhg_psg_mixer_n.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bhg_psg_mixer_n.sv
// bhg_psg_mixer_n: N-channel PSG output stage sharing one log-to-linear
// converter across channels, with panned stereo sums and master attenuation.
module bhg_psg_mixer_n #(
    parameter int  NUM_CH   = 3,
    parameter int  DAC_BITS = 10,
    localparam int SUM_BITS = DAC_BITS + $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [5*NUM_CH-1:0]        log_in,
    input  logic                       pan_we,
    input  logic [3:0]                 pan_ch,
    input  logic [1:0]                 pan_din,
    input  logic [2:0]                 master_att,
    output logic [DAC_BITS*NUM_CH-1:0] lin_out,
    output logic [SUM_BITS-1:0]        left,
    output logic [SUM_BITS-1:0]        right,
    output logic                       sample
);
    localparam int CW = $clog2(NUM_CH + 1);
    localparam int PW = DAC_BITS + 16;
    localparam logic [DAC_BITS-1:0] FULL = '1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CH);

    logic [CW-1:0]       cnt;
    logic [3:0]          tag;
    logic                primed;
    logic [DAC_BITS-1:0] lin_r;
    logic [DAC_BITS-1:0] lin_q [NUM_CH];
    logic [1:0]          pan_q [NUM_CH];
    logic [SUM_BITS-1:0] acc_l;
    logic [SUM_BITS-1:0] acc_r;

    logic [4:0]          lvl;
    logic [4:0]          d;
    logic [15:0]         mant;
    logic [PW-1:0]       prod;
    logic [4:0]          sh;
    logic [DAC_BITS-1:0] lin_next;
    logic [1:0]          pan_cur;

    always_comb begin
        lvl = 5'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (cnt == CW'(i)) lvl = log_in[5*i +: 5];
    end

    // 1.5 dB per step: 2-bit mantissa table, upper bits of d shift by 6 dB
    always_comb begin
        d = 5'd31 - lvl;
        case (d[1:0])
            2'd0:    mant = 16'd65535;
            2'd1:    mant = 16'd55109;
            2'd2:    mant = 16'd46341;
            default: mant = 16'd38968;
        endcase
        prod = PW'(FULL) * PW'(mant);
        sh   = 5'd16 + {2'b00, d[4:2]};
        if (lvl == 5'd0)
            lin_next = '0;
        else if (d == 5'd0)
            lin_next = FULL;
        else
            lin_next = DAC_BITS'(prod >> sh);
    end

    always_comb begin
        pan_cur = 2'b00;
        for (int i = 0; i < NUM_CH; i++)
            if (tag == 4'(i)) pan_cur = pan_q[i];
    end

    // Pan writes are clk-based; out-of-range channels match no register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++)
                pan_q[i] <= 2'b11;
        end else if (pan_we) begin
            for (int i = 0; i < NUM_CH; i++)
                if (pan_ch == 4'(i)) pan_q[i] <= pan_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tag    <= '0;
            primed <= 1'b0;
            lin_r  <= '0;
            acc_l  <= '0;
            acc_r  <= '0;
            left   <= '0;
            right  <= '0;
            sample <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                lin_q[i] <= '0;
        end else begin
            sample <= 1'b0;
            if (clk_en) begin
                primed <= 1'b1;
                cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (cnt != LAST) begin
                    lin_r <= lin_next;
                    tag   <= 4'(cnt);
                end
                if (cnt == '0) begin
                    acc_l <= '0;
                    acc_r <= '0;
                    // no frame has been accumulated before the first tick
                    if (primed) begin
                        left   <= acc_l >> master_att;
                        right  <= acc_r >> master_att;
                        sample <= 1'b1;
                    end
                end else begin
                    for (int i = 0; i < NUM_CH; i++)
                        if (tag == 4'(i)) lin_q[i] <= lin_r;
                    if (pan_cur[0]) acc_l <= acc_l + SUM_BITS'(lin_r);
                    if (pan_cur[1]) acc_r <= acc_r + SUM_BITS'(lin_r);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign lin_out[DAC_BITS*g +: DAC_BITS] = lin_q[g];
    end

endmodule
